tl_vc_arbiter_mux: RTL
======================

// Module: tl_vc_arbiter_mux
// PURPOSE
//  Parametrised N-channel arbitrating mux for the transaction layer. It replaces the
//  fixed 4-input priority select with valid/ready handshaking on every port.
//  It selects one valid channel per cycle, using fixed-priority or round-robin.
//  The winner's packet is registered into a one-entry output stage that feeds the
//  downstream TL datapath. The layer state input flushes the block while in INIT.
// PARAMETERS
//  WIDTH    12  data width per channel, in bits
//  NUM_CH   4   number of input channels, >=2
//  RR_MODE  0   0 = fixed priority (ch0 highest); 1 = round-robin
//  CH_W     $clog2(NUM_CH)  channel index width (derived, do not override)
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  state      in   4             TL state; ST_INIT (4'b0001) = flush
//  in_data    in   NUM_CH*WIDTH  channel i in bits [i*WIDTH +: WIDTH]
//  in_valid   in   NUM_CH        per-channel valid
//  in_ready   out  NUM_CH        per-channel ready, combinational, one-hot or zero
//  out_data   out  WIDTH         registered selected data
//  out_valid  out  1             registered valid
//  out_ch     out  CH_W          index of the source channel of out_data
//  out_ready  in   1             downstream accept
// BEHAVIOUR
//  - Reset (reset=1 at a rising edge):
//    out_data=0, out_valid=0, out_ch=0, rr_ptr=NUM_CH-1 (so ch0 wins first).
//  - Flush (state==ST_INIT, reset=0): same register values as reset.
//    in_ready=0 during flush. reset has priority over flush.
//  - load_en = !out_valid || out_ready. The stage advances on load_en; it is never
//    overwritten while holding unaccepted data.
//  - Grant (combinational, only when load_en and not flushing):
//    - RR_MODE=0: lowest-index asserted in_valid.
//    - RR_MODE=1: first asserted in_valid scanning from rr_ptr+1 upward, mod NUM_CH.
//  - in_ready[g]=1 for the granted g only. A transfer occurs on in_valid[g] && in_ready[g].
//  - On a transfer, next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1, and
//    rr_ptr<=g (RR only).
//  - load_en with no in_valid: out_valid<=0; out_data and out_ch hold their values.
//  - Latency: 1 cycle from input transfer to out_valid. Throughput: 1 packet/cycle
//    while out_ready=1.
//  - Stall (out_valid && !out_ready): in_ready=0; out_data, out_ch and rr_ptr hold.
//  - Wrap: rr_ptr=NUM_CH-1 scans from ch0. A single requester is granted every cycle.
//  - Simultaneous accept + new grant: the old word leaves and the new word loads on
//    the same edge, with no bubble.
//  - Flush mid-transfer: the pending output word is discarded. Input-side packets are
//    not consumed.
//  - rr_ptr does not move when there is no transfer, so fairness survives stalls.
// STRUCTURE
//  - Package tl_pkg holds: ST_INIT localparam (4'b0001), the TL state codes, and a
//    clog2 helper for CH_W.
//  - Sub-module tl_rr_arbiter (NUM_CH, RR_MODE): req, ptr -> one-hot gnt and index.
//  - Top level holds load_en, the output register and rr_ptr.
// TESTING
//  1 Reset: reset=1 for 2 cycles with random inputs -> out_valid=0, out_data=0,
//    in_ready=0 while reset.
//  2 Fixed priority: RR_MODE=0, in_valid=4'b1010, ch1=12'h111, ch3=12'h333,
//    out_ready=1 -> next cycle out_data=12'h111, out_ch=1; ch3 starves while ch1 valid.
//  3 Round-robin: RR_MODE=1, all 4 valid continuously, out_ready=1 ->
//    out_ch sequence 0,1,2,3,0 on consecutive cycles.
//  4 Back-pressure: out_ready=0 for 3 cycles with word 12'hABC held ->
//    out_data stays 12'hABC, in_ready=0, rr_ptr unchanged; release gives the next
//    channel in order.
//  5 Flush: state=4'b0001 while out_valid=1 -> next edge out_valid=0, out_data=0,
//    in_ready=0; state=4'b0010 resumes with ch0 first.
//  6 Empty: all in_valid=0 after word 12'h5A5 accepted -> out_valid=0,
//    out_data holds 12'h5A5.

Source files
------------

// File: rtl/tl_pkg.sv
// Transaction-layer shared definitions: link state codes and sizing helper.
package tl_pkg;

  localparam logic [3:0] ST_INIT   = 4'b0001;
  localparam logic [3:0] ST_ACTIVE = 4'b0010;
  localparam logic [3:0] ST_RECOV  = 4'b0100;
  localparam logic [3:0] ST_ERROR  = 4'b1000;

  // Ceiling log2, used to size channel index fields.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tl_vc_arbiter_mux_if.sv
// Channel-side and output-side handshake bundle for the TL arbitrating mux.
interface tl_vc_arbiter_mux_if #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned NUM_CH = 4
) ();

  localparam int unsigned CH_W = tl_pkg::clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready;

  // Traffic source / sink side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  // Arbiter side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/tl_rr_arbiter.sv
// Combinational arbiter: first requester after ptr (round-robin) or lowest index (fixed).
module tl_rr_arbiter
  import tl_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned RR_MODE = 0,
  localparam int unsigned CH_W   = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  logic [CH_W-1:0] base_c;
  logic [CH_W-1:0] cand_c;

  // Fixed priority is a scan that always starts just after the last channel.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_c = '0;
    base_c = (RR_MODE != 0) ? ptr_i : CH_W'(NUM_CH - 1);
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand_c = CH_W'((32'(base_c) + k) % NUM_CH);
      if (!any_o && req_i[cand_c]) begin
        any_o         = 1'b1;
        gnt_o[cand_c] = 1'b1;
        idx_o         = cand_c;
      end
    end
  end

endmodule

// File: rtl/tl_vc_arbiter_mux.sv
// N-channel arbitrating mux with a one-entry registered output stage and INIT flush.
module tl_vc_arbiter_mux
  import tl_pkg::*;
#(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          state,
  tl_vc_arbiter_mux_if.slave  bus
);

  localparam int unsigned CH_W = clog2(NUM_CH);

  logic              flush_c;
  logic              load_en_c;
  logic              grant_en_c;
  logic              xfer_c;
  logic [NUM_CH-1:0] gnt_c;
  logic [CH_W-1:0]   idx_c;
  logic              any_c;
  logic [WIDTH-1:0]  sel_data_c;

  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;
  logic [CH_W-1:0]   rr_ptr_q,    rr_ptr_d;

  tl_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req_i (bus.in_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_c),
    .idx_o (idx_c),
    .any_o (any_c)
  );

  // Grant only when the stage can take a word and the block is not being cleared.
  always_comb begin
    flush_c      = (state == ST_INIT);
    load_en_c    = !out_valid_q || bus.out_ready;
    grant_en_c   = load_en_c && !flush_c && !reset;
    bus.in_ready = grant_en_c ? gnt_c : '0;
    xfer_c       = grant_en_c && any_c;
  end

  // One-hot data select of the granted channel.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_c[i]) sel_data_c = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output stage next state: load on transfer, drain to empty when nothing is offered.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en_c) begin
      if (xfer_c) begin
        out_data_d  = sel_data_c;
        out_ch_d    = idx_c;
        out_valid_d = 1'b1;
        if (RR_MODE != 0) rr_ptr_d = idx_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Reset and flush both return the stage to empty with ch0 next in line.
  always_ff @(posedge clk) begin
    if (reset || flush_c) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= CH_W'(NUM_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

endmodule
